// File: rtl/bf8b_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf8b_pkg : shared opcodes, funct3 codes, ALU ops and FSM states   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package bf8b_pkg;

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_IMM    = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] C_F3_BEQ  = 3'b000;
  localparam logic [2:0] C_F3_BNE  = 3'b001;
  localparam logic [2:0] C_F3_BLT  = 3'b100;
  localparam logic [2:0] C_F3_BGE  = 3'b101;
  localparam logic [2:0] C_F3_BLTU = 3'b110;
  localparam logic [2:0] C_F3_BGEU = 3'b111;

  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;

  localparam logic [2:0] C_F3_SB = 3'b000;
  localparam logic [2:0] C_F3_SH = 3'b001;
  localparam logic [2:0] C_F3_SW = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_EXEC, ST_MEM, ST_LOAD_WB, ST_HALT
  } state_t;

  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf8b_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf8b_regfile : REG_CNT x 32 registers, 2 async reads, 1 write     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module bf8b_regfile
  import bf8b_pkg::*;
#(
  parameter int M_WIDTH = 32,
  parameter int REG_CNT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         i_ra1,
  input  logic [4:0]         i_ra2,
  input  logic               i_we,
  input  logic [4:0]         i_wa,
  input  logic [M_WIDTH-1:0] i_wd,
  output logic [M_WIDTH-1:0] o_rd1,
  output logic [M_WIDTH-1:0] o_rd2
);

  logic [M_WIDTH-1:0] reg_file [REG_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) reg_file[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      reg_file[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : reg_file[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : reg_file[i_ra2];

endmodule
`default_nettype wire

// File: rtl/bf8b_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf8b_core : multi-cycle RV32I core; define BF8B_HALT_EN to make   |
// | ECALL/EBREAK halt until reset.                        rev 1.0    |
// +------------------------------------------------------------------+
module bf8b_core
  import bf8b_pkg::*;
#(
  parameter int          M_WIDTH  = 32,
  parameter int          REG_CNT  = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [29:0]        addr,
  input  logic [M_WIDTH-1:0] data_in,
  output logic [M_WIDTH-1:0] data_out,
  output logic [3:0]         wes
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ir;
  logic [1:0]  r_off;
  logic [29:0] r_addr, w_addr_nxt;
  logic [31:0] r_dout, w_dout_nxt;
  logic [3:0]  r_wes, w_wes_nxt;

  logic        w_rf_we;
  logic [4:0]  w_rf_wa;
  logic [31:0] w_rf_wd, w_rs1, w_rs2;

  logic [31:0] w_ins;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_pc_plus4, w_ea, w_alu_b, w_alu_res;
  alu_op_t     w_alu_op;
  logic        w_take;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_wes;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_unused_ir;

  // During EXEC the instruction is still on the read bus; IR keeps it for MEM/LOAD_WB.
  assign w_ins      = data_in;
  assign w_opc      = w_ins[6:0];
  assign w_f3       = w_ins[14:12];
  assign w_rd       = w_ins[11:7];
  assign w_imm_i    = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s    = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b    = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u    = {w_ins[31:12], 12'b0};
  assign w_imm_j    = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ea       = w_rs1 + ((w_opc == C_OPC_STORE) ? w_imm_s : w_imm_i);
  assign w_alu_b    = (w_opc == C_OPC_OP) ? w_rs2 : w_imm_i;
  assign w_alu_res  = alu_eval(w_alu_op, w_rs1, w_alu_b);
  assign w_unused_ir = &{1'b0, r_ir[31:15]};

  bf8b_regfile #(
    .M_WIDTH (32),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_ins[19:15]),
    .i_ra2 (w_ins[24:20]),
    .i_we  (w_rf_we),
    .i_wa  (w_rf_wa),
    .i_wd  (w_rf_wd),
    .o_rd1 (w_rs1),
    .o_rd2 (w_rs2)
  );

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_op = ((w_opc == C_OPC_OP) && w_ins[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = w_ins[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      C_F3_BEQ:  w_take = (w_rs1 == w_rs2);
      C_F3_BNE:  w_take = (w_rs1 != w_rs2);
      C_F3_BLT:  w_take = ($signed(w_rs1) < $signed(w_rs2));
      C_F3_BGE:  w_take = !($signed(w_rs1) < $signed(w_rs2));
      C_F3_BLTU: w_take = (w_rs1 < w_rs2);
      C_F3_BGEU: w_take = !(w_rs1 < w_rs2);
      default:   w_take = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_st_data = w_rs2;
    w_st_wes  = 4'b0000;
    case (w_f3)
      C_F3_SB: begin
        w_st_data = {4{w_rs2[7:0]}};
        w_st_wes  = 4'b0001 << w_ea[1:0];
      end
      C_F3_SH: begin
        w_st_data = {2{w_rs2[15:0]}};
        w_st_wes  = w_ea[1] ? 4'b1100 : 4'b0011;
      end
      C_F3_SW: w_st_wes = 4'b1111;
      default: w_st_wes = 4'b0000;
    endcase
  end

  always_comb begin
    w_ld_data = data_in;
    case (r_off)
      2'd0:    w_ld_byte = data_in[7:0];
      2'd1:    w_ld_byte = data_in[15:8];
      2'd2:    w_ld_byte = data_in[23:16];
      default: w_ld_byte = data_in[31:24];
    endcase
    w_ld_half = r_off[1] ? data_in[31:16] : data_in[15:0];
    case (r_ir[14:12])
      C_F3_LB:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      C_F3_LH:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      C_F3_LW:  w_ld_data = data_in;
      C_F3_LBU: w_ld_data = {24'b0, w_ld_byte};
      C_F3_LHU: w_ld_data = {16'b0, w_ld_half};
      default:  w_ld_data = data_in;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_wes_nxt   = 4'b0000;
    w_dout_nxt  = r_dout;
    w_rf_we     = 1'b0;
    w_rf_wa     = r_ir[11:7];
    w_rf_wd     = '0;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = w_pc_plus4;
        w_rf_wa     = w_rd;
        case (w_opc)
          C_OPC_LUI:   begin w_rf_we = 1'b1; w_rf_wd = w_imm_u; end
          C_OPC_AUIPC: begin w_rf_we = 1'b1; w_rf_wd = r_pc + w_imm_u; end
          C_OPC_JAL: begin
            w_rf_we  = 1'b1;
            w_rf_wd  = w_pc_plus4;
            w_pc_nxt = r_pc + w_imm_j;
          end
          C_OPC_JALR: begin
            w_rf_we  = 1'b1;
            w_rf_wd  = w_pc_plus4;
            w_pc_nxt = (w_rs1 + w_imm_i) & ~32'd1;
          end
          C_OPC_BRANCH: if (w_take) w_pc_nxt = r_pc + w_imm_b;
          C_OPC_IMM, C_OPC_OP: begin w_rf_we = 1'b1; w_rf_wd = w_alu_res; end
          C_OPC_LOAD:  w_state_nxt = ST_MEM;
          C_OPC_STORE: begin
            w_state_nxt = ST_MEM;
            w_dout_nxt  = w_st_data;
            w_wes_nxt   = w_st_wes;
          end
`ifdef BF8B_HALT_EN
          C_OPC_SYSTEM: begin
            if ((w_f3 == 3'b000) && (w_ins[31:21] == 11'd0) && (w_ins[19:7] == 13'd0)) begin
              w_state_nxt = ST_HALT;
              w_pc_nxt    = r_pc;
            end
          end
`endif
          default: ;
        endcase
        if (w_state_nxt == ST_MEM)        w_addr_nxt = w_ea[31:2];
        else if (w_state_nxt == ST_FETCH) w_addr_nxt = w_pc_nxt[31:2];
      end
      ST_MEM: begin
        w_addr_nxt  = r_pc[31:2];
        w_state_nxt = (r_ir[6:0] == C_OPC_LOAD) ? ST_LOAD_WB : ST_FETCH;
      end
      ST_LOAD_WB: begin
        w_rf_we     = 1'b1;
        w_rf_wd     = w_ld_data;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Async reset on r_wes drops the enables the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC[31:2];
      r_wes  <= 4'b0000;
      r_dout <= '0;
      r_ir   <= '0;
      r_off  <= 2'd0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_addr <= w_addr_nxt;
      r_wes  <= w_wes_nxt;
      r_dout <= w_dout_nxt;
      if (r_state == ST_EXEC) begin
        r_ir  <= data_in;
        r_off <= w_ea[1:0];
      end
    end
  end

  assign addr     = r_addr;
  assign wes      = r_wes;
  assign data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_bf8b_core.sv
`default_nettype none
// Directed bench for bf8b_core: hand-encoded programs in a 4-bank byte memory.
module tb_bf8b_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr;
  logic [31:0] data_in, data_out;
  logic [3:0]  wes;
  logic [7:0]  bank [4][256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wes;

  always #5 clk = ~clk;

  bf8b_core #(.M_WIDTH(32), .REG_CNT(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out), .wes(wes)
  );

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) if (wes[n]) bank[n][addr[7:0]] <= data_out[8*n +: 8];
    data_in <= {bank[3][addr[7:0]], bank[2][addr[7:0]], bank[1][addr[7:0]], bank[0][addr[7:0]]};
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_prog();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int w = 0; w < 256; w++) for (int n = 0; n < 4; n++) bank[n][w] = 8'h00;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic put(input int widx, input logic [31:0] w);
    for (int n = 0; n < 4; n++) bank[n][widx[7:0]] = w[8*n +: 8];
  endtask

  function automatic logic [31:0] mw(input int i);
    return {bank[3][i[7:0]], bank[2][i[7:0]], bank[1][i[7:0]], bank[0][i[7:0]]};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return u_dut.u_rf.reg_file[i[4:0]];
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(7'h13, rd, 0, rs1, imm);
  endfunction
  function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input int op, input int rd, input int imm);
    return {imm[31:12], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  initial begin
    // reset state and first two instructions
    begin_prog();
    put(0, addi(10, 0, 5));
    put(1, addi(11, 10, -7));
    release_rst();
    check("reset_addr", 32'(addr), 32'h0);
    check("reset_wes", 32'(wes), 32'h0);
    check("reset_dout", data_out, 32'h0);
    tick(1); check("a0_before_exec", rf(10), 32'h0);
    tick(1); check("a0_addi", rf(10), 32'd5);
    check("addr_after_1st", 32'(addr), 32'h1);
    tick(2); check("a1_addi_neg", rf(11), 32'hFFFFFFFE);

    // store lanes
    begin_prog();
    put(0, enc_u(7'h37, 10, 32'h11223000));
    put(1, addi(10, 10, 32'h344));
    put(2, enc_s(0, 0, 10, 32'hE1));
    put(3, enc_s(1, 0, 10, 32'hE2));
    put(4, enc_s(2, 0, 10, 32'hE4));
    release_rst();
    tick(6);
    check("sb_addr", 32'(addr), 32'h38);
    check("sb_wes", 32'(wes), 32'h2);
    check("sb_lane1", 32'(data_out[15:8]), 32'h44);
    tick(1); check("wes_after_mem", 32'(wes), 32'h0);
    tick(2);
    check("sh_wes", 32'(wes), 32'hC);
    check("sh_upper", 32'(data_out[31:16]), 32'h3344);
    check("sh_addr", 32'(addr), 32'h38);
    tick(3);
    check("sw_wes", 32'(wes), 32'hF);
    check("sw_data", data_out, 32'h11223344);
    check("sw_addr", 32'(addr), 32'h39);
    tick(1);
    check("mem_38", mw(32'h38), 32'h33444400);
    check("mem_39", mw(32'h39), 32'h11223344);
    rst = 1'b1; #1;
    check("async_rst_dout", data_out, 32'h0);
    check("async_rst_addr", 32'(addr), 32'h0);
    check("async_rst_a0", rf(10), 32'h0);
    check("async_rst_ir", u_dut.r_ir, 32'h0);

    // loads
    begin_prog();
    put(0, enc_i(7'h03, 10, 0, 0, 32'hE1));
    put(1, enc_i(7'h03, 11, 4, 0, 32'hE3));
    put(2, enc_i(7'h03, 12, 1, 0, 32'hE2));
    put(3, enc_i(7'h03, 13, 5, 0, 32'hE0));
    put(4, enc_i(7'h03, 14, 2, 0, 32'hE3));
    put(32'h38, 32'h8081FF7F);
    release_rst();
    tick(2);
    check("ld_addr", 32'(addr), 32'h38);
    check("ld_wes", 32'(wes), 32'h0);
    tick(1); check("lb_not_yet", rf(10), 32'h0);
    tick(1); check("lb_off1", rf(10), 32'hFFFFFFFF);
    tick(16);
    check("lbu_off3", rf(11), 32'h80);
    check("lh_off2", rf(12), 32'hFFFF8081);
    check("lhu_off0", rf(13), 32'h0000FF7F);
    check("lw_misaligned", rf(14), 32'h8081FF7F);

    // branches and jumps
    begin_prog();
    put(0, addi(10, 0, -1));
    put(1, addi(11, 0, 1));
    put(2, enc_b(4, 10, 11, 8));
    put(3, addi(12, 0, 32'h55));
    put(4, enc_b(6, 10, 11, 8));
    put(5, addi(13, 0, 32'h66));
    put(6, enc_j(1, 8));
    put(7, addi(14, 0, 32'h77));
    put(8, addi(15, 0, 32'h12));
    put(9, addi(6, 0, 32'h31));
    put(10, enc_i(7'h67, 6, 0, 6, 0));
    put(11, addi(16, 0, 1));
    put(12, addi(17, 0, 2));
    release_rst();
    tick(6);  check("blt_taken", 32'(addr), 32'h4);
    tick(2);  check("bltu_not_taken", 32'(addr), 32'h5);
    tick(4);  check("jal_target", 32'(addr), 32'h8);
    check("jal_ra", rf(1), 32'h1C);
    tick(6);  check("jalr_target", 32'(addr), 32'hC);
    tick(2);
    check("jalr_link", rf(6), 32'h2C);
    check("skip_a2", rf(12), 32'h0);
    check("exec_a3", rf(13), 32'h66);
    check("skip_a4", rf(14), 32'h0);
    check("exec_a5", rf(15), 32'h12);
    check("skip_a6", rf(16), 32'h0);
    check("exec_a7", rf(17), 32'h2);

    // Fibonacci loop
    begin_prog();
    put(0, addi(10, 0, 0));
    put(1, addi(11, 0, 1));
    put(2, addi(12, 0, 10));
    put(3, enc_r(0, 0, 13, 10, 11));
    put(4, addi(10, 11, 0));
    put(5, addi(11, 13, 0));
    put(6, addi(12, 12, -1));
    put(7, enc_b(1, 12, 0, -16));
    put(8, enc_s(2, 0, 11, 32'hE0));
    put(9, enc_j(0, 0));
    release_rst();
    n_wes = 0;
    for (int c = 0; c < 150; c++) begin
      tick(1);
      if (wes != 4'b0000) n_wes++;
    end
    check("fib_mem", mw(32'h38), 32'd89);
    check("fib_a0", rf(10), 32'd55);
    check("fib_a1", rf(11), 32'd89);
    check("fib_a2", rf(12), 32'd0);
    check("fib_a3", rf(13), 32'd89);
    check("fib_wes_cycles", 32'(n_wes), 32'd1);

    // ALU ops
    begin_prog();
    put(0, enc_u(7'h37, 10, 32'h80000000));
    put(1, addi(11, 0, -3));
    put(2, enc_r(32'h20, 0, 12, 10, 11));
    put(3, enc_r(32'h20, 5, 13, 10, 11));
    put(4, enc_i(7'h13, 14, 5, 10, 31));
    put(5, enc_r(0, 2, 15, 11, 0));
    put(6, enc_r(0, 3, 16, 11, 0));
    put(7, enc_u(7'h17, 17, 32'h00001000));
    release_rst();
    tick(16);
    check("sub", rf(12), 32'h80000003);
    check("sra", rf(13), 32'hFFFFFFFC);
    check("srli", rf(14), 32'h1);
    check("slt", rf(15), 32'h1);
    check("sltu", rf(16), 32'h0);
    check("auipc", rf(17), 32'h101C);

    // ECALL
    begin_prog();
    put(0, 32'h00000073);
    put(1, addi(10, 0, 9));
    release_rst();
`ifdef BF8B_HALT_EN
    tick(2);  check("halt_addr", 32'(addr), 32'h0);
    tick(20); check("halt_addr_held", 32'(addr), 32'h0);
    check("halt_no_exec", rf(10), 32'h0);
    check("halt_wes", 32'(wes), 32'h0);
`else
    tick(2); check("ecall_nop_addr", 32'(addr), 32'h1);
    tick(2); check("ecall_next_instr", rf(10), 32'd9);
`endif

    // reset during a store
    begin_prog();
    put(0, addi(10, 0, 9));
    put(1, enc_s(2, 0, 10, 32'hE0));
    release_rst();
    tick(3);
    rst = 1'b1; #1;
    check("rst_exec_wes", 32'(wes), 32'h0);
    check("rst_exec_addr", 32'(addr), 32'h0);
    tick(2);
    check("rst_exec_wes_held", 32'(wes), 32'h0);
    check("rst_exec_mem", mw(32'h38), 32'h0);
    begin_prog();
    put(0, addi(10, 0, 9));
    put(1, enc_s(2, 0, 10, 32'hE0));
    release_rst();
    tick(4);
    check("store_mem_wes", 32'(wes), 32'hF);
    rst = 1'b1; #1;
    check("rst_mem_wes", 32'(wes), 32'h0);
    tick(1);
    check("rst_mem_no_write", mw(32'h38), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bf8b_core.md
# bf8b_core

Minimal multi-cycle RV32I integer core; the top-level CPU of the bf8b design, instantiated as `bf8b`. It fetches, executes and writes back one instruction at a time over a single 32-bit word-addressed synchronous memory port with per-byte write enables. Program images are split into four byte-lane banks; results are observed in memory and in the register file.

## Interface
- `M_WIDTH`, 32: data/instruction width; only 32 is supported.
- `REG_CNT`, 32: architectural registers; x0 hardwired to zero.
- `RESET_PC`, 32'h0: byte address of the first fetch.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset; one clock; asynchronous, active-high.
- `addr` output 30: word address (byte address >> 2), registered.
- `data_in` input 32: memory read data, valid one cycle after `addr` is presented.
- `data_out` output 32: store data, lane-aligned, registered.
- `wes` output 4: byte write enables; bit n writes `data_out[8n+:8]`.

## Operation
- ISA: RV32I LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP (incl. SUB, SRA/SRAI). FENCE, CSR*, unknown opcodes: NOP (pc+4). ECALL/EBREAK: see Configuration.
- States: FETCH -> EXEC -> (MEM -> LOAD_WB for loads | MEM for stores) -> FETCH.
- FETCH: `addr` = pc[31:2], `wes` = 0.
- EXEC: instruction taken from `data_in` and latched into IR; ALU, branch and jump results committed at the end of EXEC (rd written, pc updated); then FETCH with `addr` = new pc.
- Load/store in EXEC: effective address rs1+imm registered to `addr`. Stores also set `data_out` and `wes`.
- Store lanes use off = ea[1:0]:
  - SB: rs2[7:0] replicated into all lanes; `wes` = 1<<off.
  - SH: {2{rs2[15:0]}}; `wes` = 4'b0011 or 4'b1100 by off[1].
  - SW: `wes` = 4'b1111.
- Misalignment: off ignored for SW/LW; off[0] ignored for SH/LH/LHU. No traps.
- `wes` is high for exactly the one MEM cycle.
- LOAD_WB: selects byte/half lane from `data_in` by off, sign- or zero-extends, writes rd.
- Writes to x0 are discarded.
- Shifts use the low 5 bits of the shift source. Arithmetic wraps mod 2^32. SLT/branches are signed or unsigned per funct3.
- JAL/JALR: rd = pc+4. JALR target = (rs1+imm) & ~1, computed with the old rs1 when rd==rs1.
- Taken branches/jumps ignore the target's alignment (bit 1 honored, pc[1:0] dropped on fetch).

## Timing
- Reset (async assert, sync release):
  - pc = RESET_PC, state = FETCH.
  - `addr` = RESET_PC>>2, `wes` = 0, `data_out` = 0.
  - All registers and IR = 0.
- Cycles per instruction: ALU/LUI/AUIPC/branch/jump 2; store 3; load 4.
- Memory contract: memory samples `addr`/`wes`/`data_out` at the rising edge ending the cycle they are driven. Read data appears in the following cycle.
- Reset mid-instruction: aborts immediately. `wes` drops asynchronously, so no partial store commits after reset assertion.

## Configuration
- `BF8B_HALT_EN` defined: ECALL/EBREAK enter HALT.
  - HALT holds pc, `wes` = 0, `addr` frozen.
  - Left only by reset.
- Undefined: ECALL/EBREAK are NOPs.

## Structure
- Shared package `bf8b_pkg`:
  - opcode constants
  - funct3 load/store/branch codes
  - ALU op enum
  - FSM state enum
- One sub-module: `bf8b_regfile`.
  - REG_CNT x 32, two combinational read ports, one write port.
  - x0 reads 0.
  - Array named `reg_file` for hierarchical probing.

## Test plan
- Reset, program `addi a0,x0,5; addi a1,a0,-7` -> first `addr` = 0. a0=5 at cycle 2, a1=0xFFFFFFFE at cycle 4.
- Store lanes: a0=0x11223344, base 0xE0.
  - `sb a0,0xE1(x0)` -> `addr`=0x38, `wes`=4'b0010, lane1=0x44.
  - `sh a0,0xE2(x0)` -> `wes`=4'b1100, upper half 0x3344.
  - `sw` -> `wes`=4'b1111.
- Loads: word 0x38 = 0x8081FF7F.
  - `lb` off 1 -> 0xFFFFFFFF.
  - `lbu` off 3 -> 0x80.
  - `lh` off 2 -> 0xFFFF8081.
- Branch/jump:
  - `blt` with -1 < 1 taken; `bltu` same operands not taken.
  - `jal ra,+8` -> ra = pc+4, next fetch at pc+8.
- Fibonacci loop image -> word 0x38 (byte 0xE0) holds the expected Fib value; a0..a3 hold final loop state; no `wes` outside store MEM cycles.
- ECALL:
  - `BF8B_HALT_EN` defined: `addr` frozen indefinitely.
  - Undefined: next fetch at pc+4.
  - Reset asserted during a store EXEC -> `wes` 0 immediately.
